// File: rtl/vec_mag_pkg.sv
// Shared types for the vector-magnitude pipeline.
// Segment layout {x1,y1,x2,y2} is common to packer and core.
package vec_mag_pkg;

    localparam int COORD_WIDTH = 8;

    typedef struct packed {
        logic signed [COORD_WIDTH-1:0] x;
        logic signed [COORD_WIDTH-1:0] y;
    } point_t;

    typedef struct packed {
        point_t p1;
        point_t p2;
    } segment_t;

    typedef enum logic {
        IDLE,
        HAVE_PREV
    } seg_state_e;

    function automatic segment_t pack_segment(
        input point_t prev,
        input point_t cur
    );
        segment_t s;
        s.p1 = prev;
        s.p2 = cur;
        return s;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Registered main slot plus one-entry skid slot.
// in_ready comes straight from the skid register.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 33
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  main_vld_q;
    logic                  skid_vld_q;
    logic                  out_hs;

    assign out_hs    = main_vld_q && out_ready;
    assign in_ready  = !skid_vld_q;
    assign out_data  = main_q;
    assign out_valid = main_vld_q;

    // in_valid is only raised while the skid slot is empty
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            if (out_hs) begin
                if (skid_vld_q) begin
                    main_q     <= skid_q;
                    skid_vld_q <= 1'b0;
                end else begin
                    main_vld_q <= 1'b0;
                end
            end
            if (in_valid) begin
                if (!main_vld_q || out_hs) begin
                    main_q     <= in_data;
                    main_vld_q <= 1'b1;
                end else begin
                    skid_q     <= in_data;
                    skid_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vec_seg_packer.sv
// Turns a polyline point stream into one segment beat per edge.
// Single-point polylines become a degenerate {p,p} segment.
module vec_seg_packer #(
    parameter int COORD_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [2*COORD_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [4*COORD_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [CNT_WIDTH-1:0]     seg_count,
    output logic [CNT_WIDTH-1:0]     poly_count
);

    import vec_mag_pkg::*;

    localparam int PW = 2*COORD_WIDTH;
    localparam int SW = 4*COORD_WIDTH;

    seg_state_e    state_q, state_d;
    logic [PW-1:0] prev_q, prev_d;
    logic [PW-1:0] seg_first;
    logic [SW-1:0] seg_data;
    logic          accept;
    logic          emit;
    logic          emit_last;
    logic          out_hs;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign seg_first = (state_q == HAVE_PREV) ? prev_q : s_axis_tdata;

    generate
        if (COORD_WIDTH == vec_mag_pkg::COORD_WIDTH) begin : g_pkg
            assign seg_data = pack_segment(point_t'(seg_first),
                                           point_t'(s_axis_tdata));
        end else begin : g_gen
            assign seg_data = {seg_first, s_axis_tdata};
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                    end else begin
                        prev_d  = s_axis_tdata;
                        state_d = HAVE_PREV;
                    end
                end
            end
            HAVE_PREV: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_last = s_axis_tlast;
                    prev_d    = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    axis_skid_buffer #(
        .DATA_WIDTH(SW+1)
    ) u_out (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_data  ({emit_last, seg_data}),
        .in_valid (emit),
        .in_ready (s_axis_tready),
        .out_data ({m_axis_tlast, m_axis_tdata}),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

    assign out_hs = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            seg_count  <= '0;
            poly_count <= '0;
        end else if (out_hs) begin
            seg_count <= seg_count + 1'b1;
            if (m_axis_tlast) begin
                poly_count <= poly_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_seg_packer.sv
// Directed bench for vec_seg_packer with a queue-based reference model.
// A 4-bit-counter instance shares the stimulus to exercise wraparound.
module tb_vec_seg_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] seg_count;
    logic [15:0] poly_count;

    logic        s_tready4;
    logic [31:0] m_tdata4;
    logic        m_tvalid4;
    logic        m_tlast4;
    logic [3:0]  seg_count4;
    logic [3:0]  poly_count4;

    vec_seg_packer #(.COORD_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .seg_count(seg_count), .poly_count(poly_count)
    );

    vec_seg_packer #(.COORD_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready4),
        .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4),
        .m_axis_tlast(m_tlast4), .m_axis_tready(m_tready),
        .seg_count(seg_count4), .poly_count(poly_count4)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [32:0] log_q[$];
    int          hs_cyc[$];
    int          mdl_seg = 0;
    int          mdl_poly = 0;
    bit          have_prev = 0;
    logic [15:0] prev_pt = '0;
    int          sready_low = 0;
    bit          stalled = 0;
    logic [32:0] stall_beat = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model and per-cycle compare, sampled mid-cycle
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            mdl_seg   = 0;
            mdl_poly  = 0;
            have_prev = 0;
            stalled   = 0;
        end else begin
            chk("seg_count", 64'(seg_count), 64'(mdl_seg[15:0]));
            chk("poly_count", 64'(poly_count), 64'(mdl_poly[15:0]));
            chk("seg_count4", 64'(seg_count4), 64'(mdl_seg[3:0]));
            chk("poly_count4", 64'(poly_count4), 64'(mdl_poly[3:0]));
            chk("s_tready", 64'(s_tready), 64'(exp_q.size() < 2));
            chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
            if (!s_tready) sready_low++;
            if (stalled)
                chk("stable", 64'({m_tvalid, m_tlast, m_tdata}),
                    64'({1'b1, stall_beat}));
            if (m_tvalid && exp_q.size() > 0)
                chk("beat", 64'({m_tlast, m_tdata}), 64'(exp_q[0]));
            stalled    = m_tvalid && !m_tready;
            stall_beat = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                log_q.push_back({m_tlast, m_tdata});
                hs_cyc.push_back(cyc);
                mdl_seg++;
                if (m_tlast) mdl_poly++;
            end
            if (s_tvalid && s_tready) begin
                if (have_prev)
                    exp_q.push_back({s_tlast, prev_pt, s_tdata});
                else if (s_tlast)
                    exp_q.push_back({1'b1, s_tdata, s_tdata});
                have_prev = !s_tlast;
                prev_pt   = s_tdata;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        idle(1);
        aresetn = 1'b1;
    endtask

    task automatic send(input logic [15:0] p, input logic last);
        int n = 0;
        s_tdata  = p;
        s_tlast  = last;
        s_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    logic [15:0] pts[6];
    int base;
    int low0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        @(posedge aclk); #1;

        // polyline (1,2),(4,6),(10,6)
        base = log_q.size();
        send(16'h0102, 1'b0);
        send(16'h0406, 1'b0);
        send(16'h0A06, 1'b1);
        idle(3);
        chk("t1_nbeats", 64'(log_q.size() - base), 64'(2));
        chk("t1_beat0", 64'(log_q[base]), 64'({1'b0, 32'h01020406}));
        chk("t1_beat1", 64'(log_q[base+1]), 64'({1'b1, 32'h04060A06}));
        chk("t1_seg", 64'(seg_count), 64'(2));
        chk("t1_poly", 64'(poly_count), 64'(1));

        // single-point polyline then a lone non-last point
        do_reset();
        base = log_q.size();
        send(16'h03FD, 1'b1);
        idle(3);
        chk("t2_nbeats", 64'(log_q.size() - base), 64'(1));
        chk("t2_beat", 64'(log_q[base]), 64'({1'b1, 32'h03FD03FD}));
        send(16'h0707, 1'b0);
        idle(4);
        chk("t2_nobeat", 64'(log_q.size() - base), 64'(1));
        chk("t2_mvalid", 64'(m_tvalid), 64'(0));

        // 6-point polyline with downstream stall
        do_reset();
        for (int i = 0; i < 6; i++) pts[i] = 16'((i + 1) * 16'h1103);
        base = log_q.size();
        low0 = sready_low;
        fork
            begin
                for (int i = 0; i < 6; i++) send(pts[i], i == 5);
            end
            begin
                idle(2);
                m_tready = 1'b0;
                idle(3);
                m_tready = 1'b1;
            end
        join
        idle(4);
        chk("t3_nbeats", 64'(log_q.size() - base), 64'(5));
        for (int i = 0; i < 5; i++)
            chk("t3_order", 64'(log_q[base+i]),
                64'({i == 4, pts[i], pts[i+1]}));
        chk("t3_sready_dropped", 64'(sready_low > low0), 64'(1));

        // 100-point polyline at full rate
        do_reset();
        base = hs_cyc.size();
        low0 = sready_low;
        for (int i = 0; i < 100; i++) send(16'(i * 3), i == 99);
        idle(3);
        chk("t4_nbeats", 64'(hs_cyc.size() - base), 64'(99));
        if (hs_cyc.size() - base == 99)
            chk("t4_consec", 64'(hs_cyc[base+98] - hs_cyc[base]), 64'(98));
        chk("t4_sready", 64'(sready_low - low0), 64'(0));
        chk("t4_seg", 64'(seg_count), 64'(99));

        // reset with both slots full while holding a previous point
        do_reset();
        m_tready = 1'b0;
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        send(16'h0303, 1'b0);
        @(negedge aclk);
        chk("t5_full", 64'(s_tready), 64'(0));
        @(posedge aclk); #1;
        do_reset();
        @(negedge aclk);
        chk("t5_mvalid", 64'(m_tvalid), 64'(0));
        chk("t5_mtdata", 64'(m_tdata), 64'(0));
        chk("t5_sready", 64'(s_tready), 64'(1));
        chk("t5_seg", 64'(seg_count), 64'(0));
        chk("t5_poly", 64'(poly_count), 64'(0));
        @(posedge aclk); #1;
        m_tready = 1'b1;
        base = log_q.size();
        send(16'h0505, 1'b1);
        idle(3);
        chk("t5_nbeats", 64'(log_q.size() - base), 64'(1));
        chk("t5_beat", 64'(log_q[base]), 64'({1'b1, 32'h05050505}));

        // counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) send(16'(i), 1'b1);
        idle(3);
        chk("t6_seg4", 64'(seg_count4), 64'(1));
        chk("t6_poly4", 64'(poly_count4), 64'(1));
        chk("t6_seg16", 64'(seg_count), 64'(17));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
